// File: rtl/wb_shared_arbiter.sv
// wb_shared_arbiter: N-master to 1-slave classic Wishbone arbiter.
// Round-robin grant held for a whole CYC, with a stall timeout that
// answers the owner with ERR so a hung slave cannot lock the bus.
module wb_shared_arbiter #(
   parameter int unsigned NUM_MASTERS    = 4,
   parameter int unsigned AW             = 32,
   parameter int unsigned DW             = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                          wb_clk_i,
   input  logic                          wb_rst_i,
   input  logic [NUM_MASTERS-1:0]        m_cyc_i,
   input  logic [NUM_MASTERS-1:0]        m_stb_i,
   input  logic [NUM_MASTERS-1:0]        m_we_i,
   input  logic [NUM_MASTERS*DW/8-1:0]   m_sel_i,
   input  logic [NUM_MASTERS*AW-1:0]     m_adr_i,
   input  logic [NUM_MASTERS*DW-1:0]     m_dat_i,
   output logic [DW-1:0]                 m_dat_o,
   output logic [NUM_MASTERS-1:0]        m_ack_o,
   output logic [NUM_MASTERS-1:0]        m_err_o,
   output logic                          s_cyc_o,
   output logic                          s_stb_o,
   output logic                          s_we_o,
   output logic [DW/8-1:0]               s_sel_o,
   output logic [AW-1:0]                 s_adr_o,
   output logic [DW-1:0]                 s_dat_o,
   input  logic                          s_ack_i,
   input  logic                          s_err_i,
   input  logic [DW-1:0]                 s_dat_i,
   output logic [NUM_MASTERS-1:0]        grant_o,
   output logic                          timeout_o
);

   localparam int unsigned SW = DW / 8;
   localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int unsigned CW = 16;

   typedef enum logic {IDLE, OWNED} state_t;

   state_t                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [IW-1:0]          owner_q, owner_d;
   logic [IW-1:0]          ptr_q, ptr_d;
   logic [IW-1:0]          pick;
   logic                   found;
   int unsigned            idx;
   logic [CW-1:0]          cnt_q;
   logic                   timeout_q;
   logic [NUM_MASTERS-1:0] to_err_q;
   logic                   owner_cyc, owner_stb, owner_we;
   logic                   stall, expire;

   // Owner's own control lines; all zero while idle since grant is zero
   assign owner_cyc = |(m_cyc_i & grant_q);
   assign owner_stb = |(m_stb_i & grant_q);
   assign owner_we  = |(m_we_i & grant_q);

   // Stall accounting toward the timeout
   assign stall  = s_stb_o & ~s_ack_i & ~s_err_i;
   assign expire = (TIMEOUT_CYCLES != 0) && stall &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   assign m_dat_o   = s_dat_i;
   assign grant_o   = grant_q;
   assign timeout_o = timeout_q;

   // State register
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Grant, owner and round-robin pointer; pointer resets so master 0 wins first
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         grant_q <= '0;
         owner_q <= '0;
         ptr_q   <= IW'(NUM_MASTERS - 1);
      end else begin
         grant_q <= grant_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

   // Wait counter and the one-cycle timeout ERR pulse toward the owner
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
         to_err_q  <= '0;
      end else begin
         timeout_q <= expire;
         to_err_q  <= expire ? grant_q : '0;
         if ((TIMEOUT_CYCLES == 0) || !stall || expire) cnt_q <= '0;
         else                                           cnt_q <= cnt_q + CW'(1);
      end
   end

   // Next state: round-robin pick from pointer+1 upward, release when owner drops CYC
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      pick    = ptr_q;
      found   = 1'b0;
      idx     = 0;
      for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
         idx = (32'(ptr_q) + i) % NUM_MASTERS;
         if (!found && m_cyc_i[IW'(idx)]) begin
            pick  = IW'(idx);
            found = 1'b1;
         end
      end
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = OWNED;
               grant_d = NUM_MASTERS'(1) << pick;
               owner_d = pick;
            end
         end
         OWNED: begin
            if (!owner_cyc) begin
               state_d = IDLE;
               grant_d = '0;
               ptr_d   = owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs: owner mux toward the slave, ACK/ERR routed back to the owner only
   always_comb begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
      s_sel_o = '0;
      s_adr_o = '0;
      s_dat_o = '0;
      m_ack_o = '0;
      m_err_o = to_err_q;
      if (state_q == OWNED) begin
         s_cyc_o = owner_cyc;
         s_stb_o = owner_cyc & owner_stb & ~timeout_q;
         s_we_o  = owner_cyc & owner_we;
         for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
               s_sel_o = m_sel_i[i*SW +: SW];
               s_adr_o = m_adr_i[i*AW +: AW];
               s_dat_o = m_dat_i[i*DW +: DW];
            end
         end
         // A late slave response in the timeout cycle is dropped
         if (!timeout_q) begin
            m_ack_o = grant_q & {NUM_MASTERS{s_ack_i}};
            m_err_o = grant_q & {NUM_MASTERS{s_err_i}};
         end
      end
   end

endmodule

// File: tb/tb_wb_shared_arbiter.sv
// Bench for wb_shared_arbiter: cycle table with a scoreboard queue, plus
// hand sequences for contention, timeout, boundary, long stall and async reset.
module tb_wb_shared_arbiter;

   localparam int unsigned NM = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = DW / 8;

   logic              clk, rst;
   logic [NM-1:0]     m_cyc, m_stb, m_we;
   logic [NM*SW-1:0]  m_sel;
   logic [NM*AW-1:0]  m_adr;
   logic [NM*DW-1:0]  m_dat;
   logic              ack_drv, auto_ack, s_ack_i, s_err_i;
   logic [DW-1:0]     s_dat_i;

   logic [DW-1:0]     m_dat_o, s_dat_o;
   logic [NM-1:0]     m_ack_o, m_err_o, grant_o;
   logic              s_cyc_o, s_stb_o, s_we_o, timeout_o;
   logic [SW-1:0]     s_sel_o;
   logic [AW-1:0]     s_adr_o;

   logic [DW-1:0]     n_m_dat_o, n_s_dat_o;
   logic [NM-1:0]     n_m_ack_o, n_m_err_o, n_grant_o;
   logic              n_s_cyc_o, n_s_stb_o, n_s_we_o, n_timeout_o;
   logic [SW-1:0]     n_s_sel_o;
   logic [AW-1:0]     n_s_adr_o;

   int checks = 0;
   int errors = 0;

   // Slave response: explicit drive, or a one-cycle slave answering STB
   assign s_ack_i = ack_drv | (auto_ack & s_stb_o);

   wb_shared_arbiter #(.NUM_MASTERS(NM), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(8)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
      .m_sel_i(m_sel), .m_adr_i(m_adr), .m_dat_i(m_dat),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
      .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_dat_i(s_dat_i),
      .grant_o(grant_o), .timeout_o(timeout_o)
   );

   wb_shared_arbiter #(.NUM_MASTERS(NM), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(0)) dut_nto (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
      .m_sel_i(m_sel), .m_adr_i(m_adr), .m_dat_i(m_dat),
      .m_dat_o(n_m_dat_o), .m_ack_o(n_m_ack_o), .m_err_o(n_m_err_o),
      .s_cyc_o(n_s_cyc_o), .s_stb_o(n_s_stb_o), .s_we_o(n_s_we_o),
      .s_sel_o(n_s_sel_o), .s_adr_o(n_s_adr_o), .s_dat_o(n_s_dat_o),
      .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_dat_i(s_dat_i),
      .grant_o(n_grant_o), .timeout_o(n_timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] cyc, stb, we;
      logic       ack, err;
      logic [3:0] e_grant;
      logic       e_scyc, e_sstb, e_swe;
      logic [3:0] e_ack, e_err;
   } vec_t;

   typedef struct {
      logic [3:0]  grant;
      logic        scyc, sstb, swe;
      logic [3:0]  ack, err, sel;
      logic [31:0] adr, dat, mdat;
   } exp_t;

   vec_t       vecs [16];
   exp_t       exp_q [$];
   logic [3:0] grant_exp_q [$];
   logic       mon_en = 1'b0;
   logic [3:0] prev_grant;

   function automatic logic [AW-1:0] adr_of(input int i);
      return 32'h3000_0004 + 32'(i) * 32'h100;
   endfunction

   function automatic logic [DW-1:0] dat_of(input int i);
      return 32'hA5A5_0000 + 32'(i);
   endfunction

   function automatic logic [SW-1:0] sel_of(input int i);
      logic [3:0] f;
      f = 4'hF;
      return f >> i;
   endfunction

   function automatic vec_t mk(input logic [3:0] c, s, w, input logic a, e,
                               input logic [3:0] g, input logic sc, ss, sw,
                               input logic [3:0] ea, ee);
      vec_t v;
      v.cyc = c; v.stb = s; v.we = w; v.ack = a; v.err = e;
      v.e_grant = g; v.e_scyc = sc; v.e_sstb = ss; v.e_swe = sw;
      v.e_ack = ea; v.e_err = ee;
      return v;
   endfunction

   function automatic exp_t expect_row(input vec_t v, input logic [31:0] sdat);
      exp_t e;
      e.grant = v.e_grant; e.scyc = v.e_scyc; e.sstb = v.e_sstb; e.swe = v.e_swe;
      e.ack = v.e_ack; e.err = v.e_err; e.mdat = sdat;
      e.adr = '0; e.dat = '0; e.sel = '0;
      for (int i = 0; i < NM; i++) begin
         if (v.e_grant[i]) begin
            e.adr = adr_of(i); e.dat = dat_of(i); e.sel = sel_of(i);
         end
      end
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // Grant-order monitor: pops expected owner on each new grant, checks idle gap
   always @(negedge clk) begin
      if (!mon_en) begin
         prev_grant = 4'h0;
      end else begin
         if (grant_o != prev_grant)
            check("idle_gap", 64'((prev_grant != 4'h0) && (grant_o != 4'h0)), 64'(0));
         if (grant_o != 4'h0 && prev_grant == 4'h0) begin
            if (grant_exp_q.size() == 0) check("extra_grant", 64'(grant_o), 64'(0));
            else                         check("grant_order", 64'(grant_o), 64'(grant_exp_q.pop_front()));
         end
         prev_grant = grant_o;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t       e;
      logic [3:0] acked;
      int         nto_bad;
      int         pulses;

      //          cyc    stb    we     ack   err     grant scyc  sstb  swe   ack    err
      vecs[0]  = mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0,   4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
      vecs[1]  = mk(4'h1, 4'h1, 4'h0, 1'b0, 1'b0,   4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
      vecs[2]  = mk(4'h1, 4'h1, 4'h0, 1'b0, 1'b0,   4'h1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
      vecs[3]  = mk(4'h1, 4'h1, 4'h0, 1'b1, 1'b0,   4'h1, 1'b1, 1'b1, 1'b0, 4'h1, 4'h0);
      vecs[4]  = mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0,   4'h1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
      vecs[5]  = mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0,   4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
      vecs[6]  = mk(4'h4, 4'h4, 4'h4, 1'b0, 1'b0,   4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
      vecs[7]  = mk(4'h6, 4'h6, 4'h4, 1'b1, 1'b0,   4'h4, 1'b1, 1'b1, 1'b1, 4'h4, 4'h0);
      vecs[8]  = mk(4'h6, 4'h2, 4'h4, 1'b0, 1'b0,   4'h4, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0);
      vecs[9]  = mk(4'h6, 4'h6, 4'h4, 1'b1, 1'b0,   4'h4, 1'b1, 1'b1, 1'b1, 4'h4, 4'h0);
      vecs[10] = mk(4'h6, 4'h6, 4'h4, 1'b1, 1'b0,   4'h4, 1'b1, 1'b1, 1'b1, 4'h4, 4'h0);
      vecs[11] = mk(4'h2, 4'h2, 4'h0, 1'b0, 1'b0,   4'h4, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
      vecs[12] = mk(4'h2, 4'h2, 4'h0, 1'b0, 1'b0,   4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
      vecs[13] = mk(4'h2, 4'h2, 4'h0, 1'b1, 1'b1,   4'h2, 1'b1, 1'b1, 1'b0, 4'h2, 4'h2);
      vecs[14] = mk(4'h0, 4'h2, 4'h0, 1'b0, 1'b0,   4'h2, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
      vecs[15] = mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0,   4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);

      rst = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0;
      ack_drv = 1'b0; auto_ack = 1'b0; s_err_i = 1'b0; s_dat_i = 32'h1234_5678;
      for (int i = 0; i < NM; i++) begin
         m_adr[i*AW +: AW] = adr_of(i);
         m_dat[i*DW +: DW] = dat_of(i);
         m_sel[i*SW +: SW] = sel_of(i);
      end

      // Reset state
      #12;
      check("rst_grant", 64'(grant_o), 64'(0));
      check("rst_timeout", 64'(timeout_o), 64'(0));
      check("rst_scyc", 64'({s_cyc_o, s_stb_o, s_we_o}), 64'(0));
      check("rst_ack_err", 64'({m_ack_o, m_err_o}), 64'(0));
      check("rst_mdat", 64'(m_dat_o), 64'(32'h1234_5678));
      #10 rst = 1'b0;

      // Cycle table: single read, atomic hold, ACK+ERR, CYC dropped with STB high
      for (int r = 0; r < 16; r++) begin
         step();
         m_cyc = vecs[r].cyc; m_stb = vecs[r].stb; m_we = vecs[r].we;
         ack_drv = vecs[r].ack; s_err_i = vecs[r].err;
         s_dat_i = 32'hC0DE_0000 + 32'(r);
         exp_q.push_back(expect_row(vecs[r], s_dat_i));
         sample();
         e = exp_q.pop_front();
         check($sformatf("r%0d_grant", r), 64'(grant_o), 64'(e.grant));
         check($sformatf("r%0d_sctl", r), 64'({s_cyc_o, s_stb_o, s_we_o}), 64'({e.scyc, e.sstb, e.swe}));
         check($sformatf("r%0d_ack", r), 64'(m_ack_o), 64'(e.ack));
         check($sformatf("r%0d_err", r), 64'(m_err_o), 64'(e.err));
         check($sformatf("r%0d_adr", r), 64'(s_adr_o), 64'(e.adr));
         check($sformatf("r%0d_wdat", r), 64'(s_dat_o), 64'(e.dat));
         check($sformatf("r%0d_sel", r), 64'(s_sel_o), 64'(e.sel));
         check($sformatf("r%0d_mdat", r), 64'(m_dat_o), 64'(e.mdat));
         check($sformatf("r%0d_timeout", r), 64'(timeout_o), 64'(0));
      end
      ack_drv = 1'b0; s_err_i = 1'b0;

      // Reset so contention starts from master 0
      sample(); #1 rst = 1'b1;
      sample(); #1 rst = 1'b0;

      // Contention: all four masters, one transfer each, re-raise after one idle cycle
      for (int k = 0; k < 8; k++) grant_exp_q.push_back(4'(1) << (k % 4));
      auto_ack = 1'b1;
      mon_en = 1'b1;
      acked = '0;
      for (int c = 0; c < 24; c++) begin
         step();
         m_cyc = ~acked; m_stb = ~acked; m_we = '0;
         sample();
         acked = m_ack_o;
      end
      step(); m_cyc = '0; m_stb = '0;
      sample(); step(); sample();
      mon_en = 1'b0;
      auto_ack = 1'b0;
      check("contention_all_granted", 64'(grant_exp_q.size()), 64'(0));

      // Timeout: master 1 stalls, master 2 waits
      step(); m_cyc = 4'b0010; m_stb = 4'b0010;
      sample(); check("to_c0_grant", 64'(grant_o), 64'(0));
      for (int k = 1; k <= 8; k++) begin
         step();
         if (k == 5) begin m_cyc = 4'b0110; m_stb = 4'b0110; end
         sample();
         check($sformatf("to_c%0d_state", k), 64'({grant_o, s_stb_o, m_err_o, timeout_o}),
               64'({4'b0010, 1'b1, 4'b0000, 1'b0}));
      end
      step(); ack_drv = 1'b1;
      sample();
      check("to_err", 64'(m_err_o), 64'(4'b0010));
      check("to_pulse", 64'(timeout_o), 64'(1));
      check("to_stb_drop", 64'({s_cyc_o, s_stb_o}), 64'(2'b10));
      check("to_late_ack_dropped", 64'(m_ack_o), 64'(0));
      check("nto_no_err", 64'({n_m_err_o, n_timeout_o, n_s_stb_o}), 64'(1));
      step(); ack_drv = 1'b0; m_cyc = 4'b0100; m_stb = 4'b0100;
      sample();
      check("to_single_pulse", 64'({timeout_o, m_err_o}), 64'(0));
      check("to_release_grant", 64'({grant_o, s_cyc_o}), 64'({4'b0010, 1'b0}));
      step(); sample(); check("to_idle_gap", 64'(grant_o), 64'(0));
      step(); sample(); check("to_next_owner", 64'(grant_o), 64'(4'b0100));
      step(); m_cyc = '0; m_stb = '0;
      sample(); step(); sample();

      // Boundary: ACK on the 8th stall cycle is forwarded, no timeout
      step(); m_cyc = 4'b1000; m_stb = 4'b1000;
      sample();
      for (int k = 1; k <= 7; k++) begin
         step(); sample();
         check($sformatf("bd_c%0d", k), 64'({grant_o, s_stb_o, timeout_o}), 64'({4'b1000, 1'b1, 1'b0}));
      end
      step(); ack_drv = 1'b1;
      sample(); check("bd_ack", 64'({m_ack_o, m_err_o, timeout_o}), 64'({4'b1000, 4'b0000, 1'b0}));
      step(); ack_drv = 1'b0; m_cyc = '0; m_stb = '0;
      sample(); check("bd_no_timeout", 64'({m_err_o, timeout_o}), 64'(0));
      step(); sample(); check("bd_release", 64'(grant_o), 64'(0));

      // Long stall: disabled timeout never errors, enabled one pulses every 9 cycles
      step(); m_cyc = 4'b0001; m_stb = 4'b0001; m_we = 4'b0001;
      sample();
      nto_bad = 0; pulses = 0;
      for (int c = 1; c <= 1000; c++) begin
         step(); sample();
         if (n_m_err_o != 4'b0 || n_timeout_o || !n_s_stb_o) nto_bad++;
         if (timeout_o) pulses++;
      end
      check("nto_stall_clean", 64'(nto_bad), 64'(0));
      check("to_pulse_count", 64'(pulses), 64'(111));
      check("stall_grant_held", 64'(grant_o), 64'(4'b0001));
      step(); m_cyc = '0; m_stb = '0; m_we = '0;
      sample(); step(); sample();

      // Async reset in the middle of a master 3 write
      step(); m_cyc = 4'b1000; m_stb = 4'b1000; m_we = 4'b1000;
      sample();
      step(); sample();
      check("ar_owned", 64'({grant_o, s_cyc_o, s_we_o}), 64'({4'b1000, 1'b1, 1'b1}));
      #1 rst = 1'b1;
      #1;
      check("ar_async_clear", 64'({grant_o, s_cyc_o, s_stb_o, s_we_o, timeout_o}), 64'(0));
      step(); m_cyc = 4'b1001; m_stb = 4'b1001; m_we = '0;
      sample(); #1 rst = 1'b0;
      sample(); check("ar_master0_first", 64'(grant_o), 64'(4'b0001));
      step(); m_cyc = '0; m_stb = '0;
      sample(); step(); sample();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
